// File: rtl/otter_iobus_responder.sv
// Memory-mapped I/O responder for the OTTER IOBUS: board registers plus a compare/match timer.
// Latency: writes take effect on the sampling edge; read data is registered, one cycle after the address.
// Backpressure: none; the bus has no handshake, so every access completes in a single cycle.
module otter_iobus_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1100_0000,
  parameter int          PRESCALE    = 1,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  input  logic [15:0] SWITCHES,
  input  logic [4:0]  BTNS,
  output logic [15:0] LEDS,
  output logic [15:0] SSEG,
  output logic        INTR
);

  // Full byte addresses of each register; decode compares word addresses only.
  localparam logic [31:0] ADR_SW   = BASE_ADDR + 32'h00;
  localparam logic [31:0] ADR_BTN  = BASE_ADDR + 32'h04;
  localparam logic [31:0] ADR_LED  = BASE_ADDR + 32'h20;
  localparam logic [31:0] ADR_SSEG = BASE_ADDR + 32'h40;
  localparam logic [31:0] ADR_CTRL = BASE_ADDR + 32'h60;
  localparam logic [31:0] ADR_CNT  = BASE_ADDR + 32'h64;
  localparam logic [31:0] ADR_CMP  = BASE_ADDR + 32'h68;
  localparam logic [31:0] ADR_STAT = BASE_ADDR + 32'h6C;
  localparam logic [31:0] PRE_MAX  = 32'(PRESCALE - 1);

  logic [29:0] addr_w;
  logic        unused_addr_bits;
  logic [15:0] sw_sync  [SYNC_STAGES];
  logic [4:0]  btn_sync [SYNC_STAGES];
  logic        ctrl_en, ctrl_auto, ctrl_irq_en;
  logic [31:0] cnt, cmp, presc;
  logic        match;
  logic        tick, cnt_hit;
  logic        wr_led, wr_sseg, wr_ctrl, wr_cnt, wr_cmp, wr_stat;
  logic [31:0] rd_mux;

  assign addr_w           = IOBUS_ADDR[31:2];
  assign unused_addr_bits = ^IOBUS_ADDR[1:0];

  assign wr_led  = IOBUS_WR && (addr_w == ADR_LED[31:2]);
  assign wr_sseg = IOBUS_WR && (addr_w == ADR_SSEG[31:2]);
  assign wr_ctrl = IOBUS_WR && (addr_w == ADR_CTRL[31:2]);
  assign wr_cnt  = IOBUS_WR && (addr_w == ADR_CNT[31:2]);
  assign wr_cmp  = IOBUS_WR && (addr_w == ADR_CMP[31:2]);
  assign wr_stat = IOBUS_WR && (addr_w == ADR_STAT[31:2]);

  assign tick    = ctrl_en && (presc == PRE_MAX);
  assign cnt_hit = (cnt == cmp);

  // Interrupt is a pure AND of registered bits so it follows IRQ_EN with no extra delay.
  assign INTR = match & ctrl_irq_en;

  // Metastability chains for the asynchronous board inputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync[i]  <= '0;
        btn_sync[i] <= '0;
      end
    end else begin
      sw_sync[0]  <= SWITCHES;
      btn_sync[0] <= BTNS;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync[i]  <= sw_sync[i-1];
        btn_sync[i] <= btn_sync[i-1];
      end
    end
  end

  // Board-facing output registers and timer configuration, written straight from the bus.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      LEDS        <= '0;
      SSEG        <= '0;
      ctrl_en     <= 1'b0;
      ctrl_auto   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      cmp         <= '0;
    end else begin
      if (wr_led)  LEDS <= IOBUS_OUT[15:0];
      if (wr_sseg) SSEG <= IOBUS_OUT[15:0];
      if (wr_ctrl) begin
        ctrl_en     <= IOBUS_OUT[0];
        ctrl_auto   <= IOBUS_OUT[1];
        ctrl_irq_en <= IOBUS_OUT[2];
      end
      if (wr_cmp) cmp <= IOBUS_OUT;
    end
  end

  // Prescaler runs only while enabled and is parked at zero otherwise.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc <= '0;
    end else if (!ctrl_en || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 32'd1;
    end
  end

  // Counter: a CPU load wins over a tick; on a match the count reloads to zero only in auto-reload mode.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (wr_cnt) begin
      cnt <= IOBUS_OUT;
    end else if (tick) begin
      cnt <= (cnt_hit && ctrl_auto) ? 32'd0 : cnt + 32'd1;
    end
  end

  // MATCH sticky flag: setting on a matching tick wins over a same-cycle write-1-to-clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      match <= 1'b0;
    end else if (tick && cnt_hit) begin
      match <= 1'b1;
    end else if (wr_stat && IOBUS_OUT[0]) begin
      match <= 1'b0;
    end
  end

  // Read select uses pre-edge register values, so a same-cycle write returns the old contents.
  always_comb begin
    rd_mux = 32'd0;
    case (addr_w)
      ADR_SW[31:2]:   rd_mux = {16'd0, sw_sync[SYNC_STAGES-1]};
      ADR_BTN[31:2]:  rd_mux = {27'd0, btn_sync[SYNC_STAGES-1]};
      ADR_LED[31:2]:  rd_mux = {16'd0, LEDS};
      ADR_SSEG[31:2]: rd_mux = {16'd0, SSEG};
      ADR_CTRL[31:2]: rd_mux = {29'd0, ctrl_irq_en, ctrl_auto, ctrl_en};
      ADR_CNT[31:2]:  rd_mux = cnt;
      ADR_CMP[31:2]:  rd_mux = cmp;
      ADR_STAT[31:2]: rd_mux = {31'd0, match};
      default:        rd_mux = 32'd0;
    endcase
  end

  // Registered read port: one cycle from address to data.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      IOBUS_IN <= '0;
    end else begin
      IOBUS_IN <= rd_mux;
    end
  end

endmodule

// File: tb/tb_otter_iobus_responder.sv
// Directed bench for otter_iobus_responder: bus reads go through an expected-value queue.
// Latency: inputs change 1ns after a rising edge, outputs are sampled 1ns after the next one.
// Backpressure: not applicable; the bench drives one bus access per cycle.
module tb_otter_iobus_responder;

  localparam logic [31:0] BASE = 32'h1100_0000;
  localparam logic [31:0] A_SW   = BASE + 32'h00;
  localparam logic [31:0] A_BTN  = BASE + 32'h04;
  localparam logic [31:0] A_LED  = BASE + 32'h20;
  localparam logic [31:0] A_SSEG = BASE + 32'h40;
  localparam logic [31:0] A_CTRL = BASE + 32'h60;
  localparam logic [31:0] A_CNT  = BASE + 32'h64;
  localparam logic [31:0] A_CMP  = BASE + 32'h68;
  localparam logic [31:0] A_STAT = BASE + 32'h6C;
  localparam logic [31:0] A_UNM  = BASE + 32'h7C;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;
  logic [15:0] SWITCHES;
  logic [4:0]  BTNS;
  logic [15:0] LEDS;
  logic [15:0] SSEG;
  logic        INTR;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] exp_q [$];

  otter_iobus_responder #(
    .BASE_ADDR  (BASE),
    .PRESCALE   (1),
    .SYNC_STAGES(2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_OUT (IOBUS_OUT),
    .IOBUS_WR  (IOBUS_WR),
    .IOBUS_IN  (IOBUS_IN),
    .SWITCHES  (SWITCHES),
    .BTNS      (BTNS),
    .LEDS      (LEDS),
    .SSEG      (SSEG),
    .INTR      (INTR)
  );

  always #5 CLK = ~CLK;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and check the oldest queued read result.
  task automatic step_rd(input string tag);
    logic [31:0] e;
    @(posedge CLK); #1;
    e = exp_q.pop_front();
    chk(tag, IOBUS_IN, e);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    IOBUS_ADDR = addr;
    IOBUS_WR   = 1'b0;
    exp_q.push_back(exp);
    step_rd(tag);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    IOBUS_ADDR = addr;
    IOBUS_OUT  = data;
    IOBUS_WR   = 1'b1;
    @(posedge CLK); #1;
    IOBUS_WR   = 1'b0;
  endtask

  initial begin
    RST = 1'b0; IOBUS_ADDR = A_UNM; IOBUS_OUT = '0; IOBUS_WR = 1'b0;
    SWITCHES = '0; BTNS = '0;
    #2;
    chk("rst_iobus_in", IOBUS_IN, 32'd0);
    chk("rst_leds", {16'd0, LEDS}, 32'd0);
    chk("rst_sseg", {16'd0, SSEG}, 32'd0);
    chk("rst_intr", {31'd0, INTR}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;

    // LED / SSEG write, readback, upper bits dropped
    wr(A_LED, 32'h1234_ABCD);
    chk("led_out", {16'd0, LEDS}, 32'h0000_ABCD);
    rd("led_rd", A_LED, 32'h0000_ABCD);
    // read and write of the same register in one cycle returns old data
    IOBUS_ADDR = A_LED; IOBUS_OUT = 32'h0000_5555; IOBUS_WR = 1'b1;
    exp_q.push_back(32'h0000_ABCD);
    step_rd("led_rw_old");
    IOBUS_WR = 1'b0;
    chk("led_rw_new", {16'd0, LEDS}, 32'h0000_5555);
    wr(A_SSEG, 32'hFFFF_1357);
    chk("sseg_out", {16'd0, SSEG}, 32'h0000_1357);
    rd("sseg_rd", A_SSEG, 32'h0000_1357);
    wr(A_UNM, 32'hDEAD_BEEF);
    chk("unm_wr_led", {16'd0, LEDS}, 32'h0000_5555);

    // synchroniser latency: two stages, then the registered read
    SWITCHES = 16'h00F0; BTNS = 5'h15;
    IOBUS_ADDR = A_SW;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'h00F0); exp_q.push_back(32'h00F0);
    for (int i = 0; i < 4; i++) step_rd("sw_sync");
    rd("btn_rd", A_BTN, 32'h0000_0015);
    wr(A_SW, 32'hFFFF_FFFF);
    rd("sw_ro", A_SW, 32'h0000_00F0);
    rd("unmapped", A_UNM, 32'd0);

    // auto-reload timer, CMP=3: MATCH on 4th tick, count cycles 0..3
    wr(A_CMP, 32'd3);
    wr(A_CNT, 32'd0);
    wr(A_CTRL, 32'h7);
    rd("ctrl_rd", A_CTRL, 32'h7);      // tick 1: cnt 0 -> 1
    rd("cmp_rd", A_CMP, 32'd3);        // tick 2: cnt 1 -> 2
    IOBUS_ADDR = A_CNT;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(32'((i + 2) % 4));
      step_rd("cnt_reload");
      chk("intr_auto", {31'd0, INTR}, (i >= 1) ? 32'd1 : 32'd0);
    end
    wr(A_CTRL, 32'h3);
    chk("intr_irq_off", {31'd0, INTR}, 32'd0);
    wr(A_CTRL, 32'h0);
    rd("match_kept", A_STAT, 32'd1);
    wr(A_STAT, 32'd0);
    rd("stat_w0", A_STAT, 32'd1);
    wr(A_STAT, 32'd1);
    rd("stat_w1c", A_STAT, 32'd0);

    // wrap 0xFFFF_FFFF -> 0 without match
    wr(A_CMP, 32'd5);
    wr(A_CNT, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h1);
    IOBUS_ADDR = A_CNT;
    exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'd0);
    step_rd("cnt_pre_wrap");
    step_rd("cnt_wrap");
    chk("intr_wrap", {31'd0, INTR}, 32'd0);
    wr(A_CTRL, 32'h0);                 // last tick: 1 -> 2
    rd("cnt_held", A_CNT, 32'd2);
    rd("cnt_held2", A_CNT, 32'd2);
    rd("stat_wrap", A_STAT, 32'd0);

    // match set beats same-cycle W1C; CNT load beats tick
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'h1);
    wr(A_STAT, 32'd1);                 // tick with cnt==cmp: 2 -> 3, MATCH set
    wr(A_CTRL, 32'h0);                 // tick: 3 -> 4
    rd("match_vs_w1c", A_STAT, 32'd1);
    wr(A_CTRL, 32'h1);
    wr(A_CNT, 32'h100);                // tick cycle; load wins
    wr(A_CTRL, 32'h0);                 // tick: 0x100 -> 0x101
    rd("cnt_load_wins", A_CNT, 32'h101);

    // mid-run asynchronous reset
    wr(A_LED, 32'h0000_A5A5);
    wr(A_CMP, 32'd0);
    wr(A_CNT, 32'd0);
    wr(A_CTRL, 32'h7);
    IOBUS_ADDR = A_LED;
    exp_q.push_back(32'h0000_A5A5);
    step_rd("pre_rst_led");            // tick with cnt==cmp sets MATCH
    chk("pre_rst_intr", {31'd0, INTR}, 32'd1);
    #2 RST = 1'b0;
    #1;
    chk("arst_iobus_in", IOBUS_IN, 32'd0);
    chk("arst_leds", {16'd0, LEDS}, 32'd0);
    chk("arst_sseg", {16'd0, SSEG}, 32'd0);
    chk("arst_intr", {31'd0, INTR}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    rd("post_rst_cnt", A_CNT, 32'd0);
    rd("post_rst_ctrl", A_CTRL, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
